// File: rtl/vc4000_cart_loader.sv
// rtl/vc4000_cart_loader.sv - ioctl cartridge download to req/ack ROM store writer.
// Optional fill of unloaded space with FILL_BYTE when VC4000_CART_FILL_EN is defined.
module vc4000_cart_loader #(
  parameter int          ADDR_W     = 15,
  parameter logic [7:0]  CART_INDEX = 8'd1,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   cart_size,
  output logic [ADDR_W-1:0] cart_mask,
  output logic              cart_loaded,
  output logic              overflow,
  output logic              core_reset
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
`ifdef VC4000_CART_FILL_EN
    FILL,
`endif
    DONE
  } state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic              dl_q, dl_d;
  logic              wait_q, wait_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W:0]   cart_size_q, cart_size_d;
  logic              cart_loaded_q, cart_loaded_d;
  logic              overflow_q, overflow_d;
  logic              core_reset_q, core_reset_d;
  logic              restart_q, restart_d;

  logic              start;
  logic              in_range;
  logic [ADDR_W:0]   addr_p1;
  logic              go_load;
  logic              go_end;
  logic [ADDR_W-1:0] mask;

`ifndef VC4000_CART_FILL_EN
  logic [7:0] unused_fill_byte;
  assign unused_fill_byte = FILL_BYTE;
`endif

  always_comb begin
    state_d       = state_q;
    dl_d          = ioctl_download;
    wait_d        = wait_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_req_d     = mem_req_q;
    cart_size_d   = cart_size_q;
    cart_loaded_d = cart_loaded_q;
    overflow_d    = overflow_q;
    core_reset_d  = core_reset_q;
    restart_d     = restart_q;
    go_load       = 1'b0;
    go_end        = 1'b0;

    start    = ioctl_download && !dl_q && (ioctl_index == CART_INDEX);
    in_range = (ioctl_addr[24:ADDR_W] == '0);
    addr_p1  = {1'b0, ioctl_addr[ADDR_W-1:0]} + (ADDR_W+1)'(1);

    case (state_q)
      IDLE: begin
        if (start) go_load = 1'b1;
      end
      LOAD: begin
        if (!ioctl_download) begin
          go_end = 1'b1;
        end else if (ioctl_wr) begin
          if (in_range) begin
            mem_addr_d = ioctl_addr[ADDR_W-1:0];
            mem_data_d = ioctl_dout;
            mem_req_d  = 1'b1;
            wait_d     = 1'b1;
            state_d    = WRITE;
            if (addr_p1 > cart_size_q) cart_size_d = addr_p1;
          end else begin
            overflow_d  = 1'b1;
            cart_size_d = CAP;
          end
        end
      end
      WRITE: begin
        // A download that ended during the write is finished once the byte lands.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          wait_d    = 1'b0;
          if (!ioctl_download) go_end = 1'b1;
          else                 state_d = LOAD;
        end
      end
`ifdef VC4000_CART_FILL_EN
      FILL: begin
        if (start) restart_d = 1'b1;
        if (mem_ack) begin
          if (restart_q || start) begin
            mem_req_d = 1'b0;
            restart_d = 1'b0;
            go_load   = 1'b1;
          end else if (mem_addr_q == {ADDR_W{1'b1}}) begin
            mem_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
          end
        end
      end
`endif
      DONE: begin
        cart_loaded_d = (cart_size_q != '0);
        core_reset_d  = 1'b0;
        if (start) go_load = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (go_end) begin
`ifdef VC4000_CART_FILL_EN
      if (cart_size_q == CAP) begin
        state_d = DONE;
      end else begin
        state_d    = FILL;
        mem_addr_d = cart_size_q[ADDR_W-1:0];
        mem_data_d = FILL_BYTE;
        mem_req_d  = 1'b1;
      end
`else
      state_d = DONE;
`endif
    end

    if (go_load) begin
      state_d       = LOAD;
      cart_size_d   = '0;
      overflow_d    = 1'b0;
      cart_loaded_d = 1'b0;
      core_reset_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      dl_q          <= ioctl_download;
      wait_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_req_q     <= 1'b0;
      cart_size_q   <= '0;
      cart_loaded_q <= 1'b0;
      overflow_q    <= 1'b0;
      core_reset_q  <= 1'b1;
      restart_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      dl_q          <= dl_d;
      wait_q        <= wait_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_req_q     <= mem_req_d;
      cart_size_q   <= cart_size_d;
      cart_loaded_q <= cart_loaded_d;
      overflow_q    <= overflow_d;
      core_reset_q  <= core_reset_d;
      restart_q     <= restart_d;
    end
  end

  // Mirror mask: smear the highest set bit of (size-1) downward.
  always_comb begin
    mask = cart_size_q[ADDR_W-1:0] - ADDR_W'(1);
    for (int i = ADDR_W - 2; i >= 0; i--) mask[i] = mask[i] | mask[i+1];
    if (cart_size_q == '0) mask = '0;
  end

  assign ioctl_wait  = wait_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_req     = mem_req_q;
  assign cart_size   = cart_size_q;
  assign cart_mask   = mask;
  assign cart_loaded = cart_loaded_q;
  assign overflow    = overflow_q;
  assign core_reset  = core_reset_q;

endmodule
